// File: rtl/axi_lite_master_if.sv
// AXI4-lite channel bundle between the NPC initiator bridge and a responder.
interface axi_lite_master_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding CPU request -> AXI4-lite read/write bridge.
// Optional: define AXIM_ALIGN_CHECK_EN to reject misaligned requests without AXI traffic.
module axi_lite_master (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_wen,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  input  logic [3:0]               req_wstrb,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  axi_lite_master_if.master        axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B,
    S_RESP
  } state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_fin;
  logic   w_fin;
  logic   misaligned;

  always_comb begin
    aw_fin = aw_done | (axi.awvalid & axi.awready);
    w_fin  = w_done  | (axi.wvalid  & axi.wready);
  end

`ifdef AXIM_ALIGN_CHECK_EN
  always_comb misaligned = (req_addr[1:0] != 2'b00);
`else
  always_comb misaligned = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= S_IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      axi.araddr  <= '0;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      axi.awaddr  <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            if (misaligned) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state      <= S_RESP;
            end else if (req_wen) begin
              axi.awaddr  <= req_addr;
              axi.wdata   <= req_wdata;
              axi.wstrb   <= {4'b0000, req_wstrb};
              axi.awvalid <= 1'b1;
              axi.wvalid  <= 1'b1;
              state       <= S_AW_W;
            end else begin
              axi.araddr  <= req_addr;
              axi.arvalid <= 1'b1;
              state       <= S_AR;
            end
          end
        end

        S_AR: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            state       <= S_R;
          end
        end

        S_R: begin
          if (axi.rvalid) begin
            axi.rready <= 1'b0;
            resp_rdata <= axi.rdata;
            resp_err   <= (axi.rresp != 2'b00);
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end

        // Address and data channels retire independently; leave once both have.
        S_AW_W: begin
          if (axi.awvalid && axi.awready) begin
            axi.awvalid <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (axi.wvalid && axi.wready) begin
            axi.wvalid <= 1'b0;
            w_done     <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            axi.bready <= 1'b1;
            state      <= S_B;
          end
        end

        S_B: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= (axi.bresp != 2'b00);
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end
        end

        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Randomized bench for axi_lite_master: bench-side AXI responder plus transaction-level expectations.
module tb_axi_lite_master;

  logic        aclk;
  logic        aresetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  axi_lite_master_if bus ();

  axi_lite_master dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .axi        (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Responder controls and what it observed / returned
  bit          fast_mode = 1'b0;
  bit          ar_block  = 1'b0;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_data = '0;
  logic [1:0]  fixed_resp = '0;
  int          ar_hs = 0, aw_hs = 0, w_hs = 0, r_hs = 0, b_hs = 0, valid_cycles = 0;
  logic [31:0] ar_addr_q = '0, aw_addr_q = '0, w_data_q = '0;
  logic [7:0]  w_strb_q = '0;
  logic [31:0] last_rdata = '0;
  logic [1:0]  last_rresp = '0, last_bresp = '0;

  function automatic logic [1:0] rand_resp();
    if ($urandom_range(0, 3) == 0) return 2'($urandom_range(1, 3));
    return 2'b00;
  endfunction

  function automatic logic rand_ready();
    if (fast_mode) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  initial begin
    bit hs_ar, hs_r, hs_aw, hs_w, hs_b;
    bit pend_ar, pend_aw, pend_w, post_ar, post_aw, post_w;
    bit r_pend, b_pend, aw_got, w_got;
    int r_dly, b_dly;
    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic [7:0]  s_wstrb;
    {hs_ar, hs_r, hs_aw, hs_w, hs_b} = '0;
    {pend_ar, pend_aw, pend_w, post_ar, post_aw, post_w} = '0;
    {r_pend, b_pend, aw_got, w_got} = '0;
    r_dly = 0; b_dly = 0;
    s_araddr = '0; s_awaddr = '0; s_wdata = '0; s_wstrb = '0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        {hs_ar, hs_r, hs_aw, hs_w, hs_b} = '0;
        {pend_ar, pend_aw, pend_w, post_ar, post_aw, post_w} = '0;
      end else begin
        // A valid must hold with a stable payload until accepted, then drop.
        if (pend_ar) chk("ar_hold", 64'({bus.arvalid, bus.araddr}), 64'({1'b1, s_araddr}));
        if (pend_aw) chk("aw_hold", 64'({bus.awvalid, bus.awaddr}), 64'({1'b1, s_awaddr}));
        if (pend_w)  chk("w_hold",  64'({bus.wvalid, bus.wstrb, bus.wdata}), 64'({1'b1, s_wstrb, s_wdata}));
        if (post_ar) chk("ar_drop", 64'(bus.arvalid), 64'd0);
        if (post_aw) chk("aw_drop", 64'(bus.awvalid), 64'd0);
        if (post_w)  chk("w_drop",  64'(bus.wvalid), 64'd0);
        hs_ar = bus.arvalid && bus.arready;
        hs_aw = bus.awvalid && bus.awready;
        hs_w  = bus.wvalid  && bus.wready;
        hs_r  = bus.rvalid  && bus.rready;
        hs_b  = bus.bvalid  && bus.bready;
        pend_ar = bus.arvalid && !bus.arready;
        pend_aw = bus.awvalid && !bus.awready;
        pend_w  = bus.wvalid  && !bus.wready;
        post_ar = hs_ar; post_aw = hs_aw; post_w = hs_w;
        s_araddr = bus.araddr; s_awaddr = bus.awaddr;
        s_wdata = bus.wdata; s_wstrb = bus.wstrb;
        if (bus.arvalid || bus.awvalid || bus.wvalid) valid_cycles++;
      end
      @(posedge aclk);
      #1;
      if (!aresetn) begin
        {r_pend, b_pend, aw_got, w_got} = '0;
        bus.rvalid = 1'b0;
        bus.bvalid = 1'b0;
      end else begin
        if (hs_ar) begin
          ar_hs++; ar_addr_q = s_araddr;
          r_pend = 1'b1; r_dly = fast_mode ? 0 : int'($urandom_range(0, 2));
        end
        if (hs_r) begin bus.rvalid = 1'b0; r_hs++; end
        if (hs_aw) begin aw_hs++; aw_addr_q = s_awaddr; aw_got = 1'b1; end
        if (hs_w)  begin w_hs++; w_data_q = s_wdata; w_strb_q = s_wstrb; w_got = 1'b1; end
        if (hs_b)  begin bus.bvalid = 1'b0; b_hs++; end
        if (aw_got && w_got) begin
          aw_got = 1'b0; w_got = 1'b0;
          b_pend = 1'b1; b_dly = fast_mode ? 0 : int'($urandom_range(0, 2));
        end
        if (r_pend) begin
          if (r_dly == 0) begin
            bus.rvalid = 1'b1;
            bus.rdata  = use_fixed ? fixed_data : $urandom;
            bus.rresp  = use_fixed ? fixed_resp : rand_resp();
            last_rdata = bus.rdata; last_rresp = bus.rresp;
            r_pend = 1'b0;
          end else r_dly--;
        end
        if (b_pend) begin
          if (b_dly == 0) begin
            bus.bvalid = 1'b1;
            bus.bresp  = use_fixed ? fixed_resp : rand_resp();
            last_bresp = bus.bresp;
            b_pend = 1'b0;
          end else b_dly--;
        end
      end
      bus.arready = ar_block ? 1'b0 : rand_ready();
      bus.awready = rand_ready();
      bus.wready  = rand_ready();
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // One CPU transaction; expectations come from the request and what the responder returned.
  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] st, input int hold);
    int ar0, aw0, w0, vc0, lat, n;
    bit reject;
    logic [31:0] exp_rdata;
    logic        exp_err;
`ifdef AXIM_ALIGN_CHECK_EN
    reject = (addr[1:0] != 2'b00);
`else
    reject = 1'b0;
`endif
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    ar0 = ar_hs; aw0 = aw_hs; w0 = w_hs; vc0 = valid_cycles;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wd; req_wstrb = st;
    lat = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
        chk("req_ready_fall", 64'(req_ready), 64'd0);
      end
    end while (!resp_valid && lat < 60);
    chk("resp_timeout", 64'(resp_valid), 64'd1);
    if (fast_mode) chk("latency", 64'(lat), reject ? 64'd1 : 64'd3);

    if (reject) begin
      exp_rdata = '0; exp_err = 1'b1;
    end else if (wen) begin
      exp_rdata = '0; exp_err = (last_bresp != 2'b00);
    end else begin
      exp_rdata = last_rdata; exp_err = (last_rresp != 2'b00);
    end

    // Hold off the response; a competing request must not be taken.
    for (int i = 0; i <= hold; i++) begin
      chk("resp_valid_hold", 64'(resp_valid), 64'd1);
      chk("resp_rdata", 64'(resp_rdata), 64'(exp_rdata));
      chk("resp_err", 64'(resp_err), 64'(exp_err));
      chk("req_ready_busy", 64'(req_ready), 64'd0);
      if (i < hold) begin
        req_valid = 1'b1; req_wen = 1'($urandom); req_addr = $urandom & 32'hffff_fffc;
        tick();
      end
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_valid_drop", 64'(resp_valid), 64'd0);
    chk("req_ready_back", 64'(req_ready), 64'd1);

    if (reject) begin
      chk("no_axi_traffic", 64'(valid_cycles - vc0), 64'd0);
    end else if (wen) begin
      chk("aw_count", 64'(aw_hs - aw0), 64'd1);
      chk("w_count", 64'(w_hs - w0), 64'd1);
      chk("ar_count_w", 64'(ar_hs - ar0), 64'd0);
      chk("awaddr", 64'(aw_addr_q), 64'(addr));
      chk("wdata", 64'(w_data_q), 64'(wd));
      chk("wstrb", 64'(w_strb_q), 64'({4'b0000, st}));
    end else begin
      chk("ar_count", 64'(ar_hs - ar0), 64'd1);
      chk("aw_count_r", 64'(aw_hs - aw0), 64'd0);
      chk("araddr", 64'(ar_addr_q), 64'(addr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    bit seen_resp, seen_ar;
    aresetn = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_valids", 64'({bus.arvalid, bus.awvalid, bus.wvalid, resp_valid}), 64'd0);
    chk("rst_readies", 64'({bus.rready, bus.bready}), 64'd0);
    chk("rst_resp", 64'({resp_err, resp_rdata}), 64'd0);
    chk("rst_payload", 64'({bus.araddr, bus.awaddr}), 64'd0);
    chk("rst_wpayload", 64'({bus.wstrb, bus.wdata}), 64'd0);
    aresetn = 1'b1;

    fast_mode = 1'b1;
    repeat (2) tick();
    use_fixed = 1'b1; fixed_data = 32'h1234_5678; fixed_resp = 2'b00;
    run_txn(1'b0, 32'ha000_0048, 32'h0, 4'h0, 0);
    chk("directed_rdata", 64'(last_rdata), 64'h1234_5678);
    fixed_resp = 2'b10;
    run_txn(1'b1, 32'h8000_0000, 32'hdead_beef, 4'b0011, 0);
    use_fixed = 1'b0;
    run_txn(1'b0, 32'h8000_0002, 32'h0, 4'h0, 0);
    run_txn(1'b1, 32'h8000_0006, 32'h0bad_cafe, 4'b1100, 5);

    fast_mode = 1'b0;
    repeat (2) tick();
    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      run_txn(1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(0, 5)));
    end

    // Reset while a read sits in AR with arvalid raised.
    ar_block = 1'b1;
    repeat (2) tick();
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0100;
    tick();
    req_valid = 1'b0;
    tick();
    chk("ar_pending", 64'(bus.arvalid), 64'd1);
    #3 aresetn = 1'b0;
    #1;
    chk("rst_arvalid", 64'(bus.arvalid), 64'd0);
    chk("rst_req_ready2", 64'(req_ready), 64'd1);
    tick();
    #2 aresetn = 1'b1;
    ar_block = 1'b0;
    seen_resp = 1'b0; seen_ar = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen_resp |= resp_valid;
      seen_ar   |= bus.arvalid;
    end
    chk("no_resp_after_rst", 64'(seen_resp), 64'd0);
    chk("no_ar_after_rst", 64'(seen_ar), 64'd0);
    chk("idle_after_rst", 64'(req_ready), 64'd1);
    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
# axi_lite_master

Initiator-side AXI4-lite bridge for the NPC core. It converts a single-outstanding CPU memory request (from the IFU or LSU) into one AXI4-lite read or write transaction toward a responder such as the CLINT or the memory model, then returns the read data and status to the CPU. At most one transaction is in flight; reads and writes never overlap.

## Interface
- No parameters.
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `req_valid` in 1: CPU request valid.
- `req_ready` out 1: bridge can accept a request; high only in IDLE.
- `req_wen` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: write data.
- `req_wstrb` in 4: byte enables.
- `resp_valid` out 1: response valid; held until `resp_ready`.
- `resp_ready` in 1: CPU accepts the response.
- `resp_rdata` out 32: read data; 0 for writes.
- `resp_err` out 1: 1 if the `rresp`/`bresp` value was nonzero.
- `araddr` out 32, `arvalid` out 1, `arready` in 1: read address channel.
- `rdata` in 32, `rresp` in 2, `rvalid` in 1, `rready` out 1: read data channel.
- `awaddr` out 32, `awvalid` out 1, `awready` in 1: write address channel.
- `wdata` out 32, `wstrb` out 8, `wvalid` out 1, `wready` in 1: write data channel. `wstrb[7:4]` is always 0.
- `bresp` in 2, `bvalid` in 1, `bready` out 1: write response channel.

## Operation
- FSM states: IDLE, AR, R, AW_W, B, RESP.
- IDLE: `req_ready`=1. When `req_valid`=1, latch addr/wdata/wstrb/wen. Next state is AR for a read or AW_W for a write.
- AR: `arvalid`=1, `araddr`=latched addr. Stay until `arready`, then go to R.
- R: `rready`=1. On `rvalid`, capture `rdata` and set err = (`rresp`!=0). Go to RESP.
- AW_W:
  - `awvalid` and `wvalid` assert together on state entry.
  - Each deasserts in the cycle after its own handshake (`awready`/`wready`), tracked by flags `aw_done` and `w_done`.
  - Go to B when both are done. Both may complete in the same cycle, and they may complete in either order.
- B: `bready`=1. On `bvalid`, set err = (`bresp`!=0) and `resp_rdata`=0. Go to RESP.
- RESP: `resp_valid`=1 with data and err stable. On `resp_ready`, return to IDLE.
- All AXI outputs (valid, ready, address, data, strobe) are registered. Once a valid is asserted, its payload does not change until the handshake completes.
- Responder ready signals asserted before valid (for example, `arready` already high) are legal. The handshake then completes in the first valid cycle.
- Reset (async, any state): state=IDLE. All valids and readies drive 0, except `req_ready`, which is 1 after reset. `resp_rdata`=0, `resp_err`=0, addresses/data/strobes=0. A transaction interrupted by reset is dropped; no response is returned.

## Timing
- Request acceptance to `arvalid`/`awvalid`: 1 cycle.
- Minimum read latency, from `req_valid`&`req_ready` to `resp_valid`, with all responder readies and valids high immediately: 3 cycles (IDLE→AR→R→RESP).
- Minimum write latency: 3 cycles (IDLE→AW_W→B→RESP).
- `req_ready` falls in the cycle after acceptance. It returns to 1 in the cycle after the `resp_valid`&`resp_ready` handshake, so back-to-back requests are separated by at least 1 idle cycle.
- `rready` is high only in R. `bready` is high only in B.

## Configuration
- `AXIM_ALIGN_CHECK_EN` defined:
  - A request whose `req_addr[1:0]`!=0 is rejected with no AXI traffic.
  - The FSM goes IDLE→RESP with `resp_err`=1 and `resp_rdata`=0; `resp_valid` rises 1 cycle after acceptance.
- `AXIM_ALIGN_CHECK_EN` undefined: no alignment check. The address is passed unchanged to `araddr`/`awaddr`.

## Test plan
- Read from 32'ha0000048 with the responder returning rdata=32'h1234_5678, rresp=0 → `araddr`=32'ha0000048, `resp_rdata`=32'h1234_5678, `resp_err`=0, `resp_valid` 3 cycles after acceptance.
- Write of data 32'hdead_beef, strb 4'b0011 to 32'h8000_0000, with `wready` 2 cycles later than `awready` → `awvalid` drops first, `wvalid` holds, `wstrb`=8'h03, then `bready`. `bresp`=2'b10 → `resp_err`=1, `resp_rdata`=0.
- `resp_ready` held low for 5 cycles → `resp_valid`/data/err stable for 5 cycles; `req_ready` stays 0 and a new `req_valid` is not accepted.
- `aresetn` pulsed low while in AR with `arvalid`=1 → `arvalid`=0 immediately; after release, `req_ready`=1 and no `resp_valid` appears.
- With `AXIM_ALIGN_CHECK_EN` defined, read of 32'h8000_0002 → no `arvalid`; `resp_valid`=1, `resp_err`=1 next cycle. Without the macro, `arvalid` asserts with `araddr`=32'h8000_0002.
- Responder `arready`, `awready`, `wready` tied high → each valid is high for exactly 1 cycle; read and write latencies are 3 cycles each.
